// File: rtl/lif_pkg.sv
// Shared types and sizing for the LIF neuron scheduler.
// Widths derive from N_NEURONS and N_STAGES so the top, interface and bank stay consistent.
package lif_pkg;

  localparam int unsigned N_NEURONS      = 4;
  localparam int unsigned N_STAGES       = 5;
  localparam int unsigned MEMBRANE_BITS  = N_STAGES + 2;
  localparam int unsigned THRESHOLD_BITS = MEMBRANE_BITS - 1;
  localparam int unsigned INPUTS         = 2 ** N_STAGES;
  localparam int unsigned WEIGHTS        = INPUTS;
  localparam int unsigned BYTES_PER_VEC  = INPUTS / 8;
  localparam int unsigned IDX_BITS       = $clog2(N_NEURONS);
  // Keep the byte counter at least one bit wide when a vector is a single byte.
  localparam int unsigned CNT_BITS       = (BYTES_PER_VEC > 1) ? $clog2(BYTES_PER_VEC) : 1;

  localparam logic KIND_INPUT  = 1'b0;
  localparam logic KIND_WEIGHT = 1'b1;

  typedef enum logic [1:0] {
    StLoad = 2'd0,
    StRun  = 2'd1,
    StOut  = 2'd2
  } state_e;

endpackage

// File: rtl/lif_scheduler_if.sv
// Byte-stream input and spike-vector output handshakes of the scheduler.
// The master side is the tile pin logic; the slave side is lif_scheduler.
interface lif_scheduler_if;
  import lif_pkg::*;

  logic [7:0]           in_data;
  logic                 in_kind;
  logic [IDX_BITS-1:0]  in_neuron;
  logic                 in_valid;
  logic                 in_ready;
  logic [N_NEURONS-1:0] out_spikes;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_kind, in_neuron, in_valid, out_ready,
    input  in_ready, out_spikes, out_valid
  );

  modport slave (
    input  in_data, in_kind, in_neuron, in_valid, out_ready,
    output in_ready, out_spikes, out_valid
  );

endinterface

// File: rtl/lif_state_bank.sv
// Per-neuron private state: weight vector, membrane and spike flag.
// One read port, one membrane/spike write port, one weight byte-shift port and a clear.
module lif_state_bank
  import lif_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_clr,
  input  logic [IDX_BITS-1:0]             i_rd_idx,
  output logic [WEIGHTS-1:0]              o_rd_weights,
  output logic signed [MEMBRANE_BITS-1:0] o_rd_membrane,
  output logic                            o_rd_spike,
  output logic [N_NEURONS-1:0]            o_spikes,
  input  logic                            i_mem_we,
  input  logic [IDX_BITS-1:0]             i_mem_idx,
  input  logic signed [MEMBRANE_BITS-1:0] i_mem_data,
  input  logic                            i_spk_data,
  input  logic                            i_w_we,
  input  logic [IDX_BITS-1:0]             i_w_idx,
  input  logic [7:0]                      i_w_byte
);

  logic [WEIGHTS-1:0]              r_w   [N_NEURONS];
  logic signed [MEMBRANE_BITS-1:0] r_mem [N_NEURONS];
  logic [N_NEURONS-1:0]            r_spk;

  // Weights reset to all-ones so every input contributes +1 until reloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        r_w[i] <= '1;
      end
    end else if (i_w_we) begin
      r_w[i_w_idx] <= (r_w[i_w_idx] << 8) | WEIGHTS'(i_w_byte);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        r_mem[i] <= '0;
      end
      r_spk <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        r_mem[i] <= '0;
      end
      r_spk <= '0;
    end else if (i_mem_we) begin
      r_mem[i_mem_idx] <= i_mem_data;
      r_spk[i_mem_idx] <= i_spk_data;
    end
  end

  assign o_rd_weights  = r_w[i_rd_idx];
  assign o_rd_membrane = r_mem[i_rd_idx];
  assign o_rd_spike    = r_spk[i_rd_idx];
  assign o_spikes      = r_spk;

endmodule

// File: rtl/lif_scheduler.sv
// Time-multiplexes one external LIF datapath over N_NEURONS virtual neurons.
// LOAD collects the input vector byte-wise, RUN sweeps the neurons, OUT presents the spikes.
module lif_scheduler
  import lif_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  lif_scheduler_if.slave                   bus,
  input  logic                             i_clr,
  input  logic [THRESHOLD_BITS-1:0]        i_cfg_threshold,
  input  logic [2:0]                       i_cfg_shift,
  output logic                             o_busy,
  output logic [INPUTS-1:0]                o_dp_inputs,
  output logic [WEIGHTS-1:0]               o_dp_weights,
  output logic signed [MEMBRANE_BITS-1:0]  o_dp_last_membrane,
  output logic                             o_dp_was_spike,
  output logic [THRESHOLD_BITS-1:0]        o_dp_threshold,
  output logic [2:0]                       o_dp_shift,
  input  logic signed [MEMBRANE_BITS-1:0]  i_dp_new_membrane,
  input  logic                             i_dp_is_spike
);

  state_e              r_state;
  logic [CNT_BITS-1:0] r_byte_cnt;
  logic [IDX_BITS-1:0] r_idx;
  logic [INPUTS-1:0]   r_vec;

  logic w_load;
  logic w_run;
  logic w_accept;
  logic w_in_byte;
  logic w_w_byte;
  logic w_last_byte;
  logic w_last_idx;

  assign w_load      = (r_state == StLoad);
  assign w_run       = (r_state == StRun);
  assign w_accept    = w_load & bus.in_valid;
  assign w_in_byte   = w_accept & (bus.in_kind == KIND_INPUT);
  assign w_w_byte    = w_accept & (bus.in_kind == KIND_WEIGHT);
  assign w_last_byte = (r_byte_cnt == CNT_BITS'(BYTES_PER_VEC - 1));
  assign w_last_idx  = (r_idx == IDX_BITS'(N_NEURONS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StLoad;
      r_byte_cnt <= '0;
      r_idx      <= '0;
      r_vec      <= '0;
    end else begin
      case (r_state)
        StLoad: begin
          // First byte of a vector ends up in the MSBs.
          if (w_in_byte) begin
            r_vec <= (r_vec << 8) | INPUTS'(bus.in_data);
            if (w_last_byte) begin
              r_byte_cnt <= '0;
              r_state    <= StRun;
            end else begin
              r_byte_cnt <= r_byte_cnt + CNT_BITS'(1);
            end
          end
        end
        StRun: begin
          if (w_last_idx) begin
            r_idx   <= '0;
            r_state <= StOut;
          end else begin
            r_idx <= r_idx + IDX_BITS'(1);
          end
        end
        StOut: begin
          if (bus.out_ready) begin
            r_state <= StLoad;
          end
        end
        default: r_state <= StLoad;
      endcase
    end
  end

  // Clear is honoured only between vectors so a sweep never sees a half-cleared bank.
  lif_state_bank u_bank (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr        (i_clr & w_load),
    .i_rd_idx     (r_idx),
    .o_rd_weights (o_dp_weights),
    .o_rd_membrane(o_dp_last_membrane),
    .o_rd_spike   (o_dp_was_spike),
    .o_spikes     (bus.out_spikes),
    .i_mem_we     (w_run),
    .i_mem_idx    (r_idx),
    .i_mem_data   (i_dp_new_membrane),
    .i_spk_data   (i_dp_is_spike),
    .i_w_we       (w_w_byte),
    .i_w_idx      (bus.in_neuron),
    .i_w_byte     (bus.in_data)
  );

  assign bus.in_ready   = w_load;
  assign bus.out_valid  = (r_state == StOut);
  assign o_busy         = ~w_load;
  assign o_dp_inputs    = r_vec;
  assign o_dp_threshold = i_cfg_threshold;
  assign o_dp_shift     = i_cfg_shift;

endmodule
